// File: rtl/b_redirect_ctrl.sv
// Branch resolution receiver: detects mispredicts, flushes the backend, holds a redirect PC, queues predictor updates.
// Latency: accept in cycle N -> flush_o / redir_valid_o / upd_valid_o visible in cycle N+1.
// Backpressure: res_ready_o low while a redirect is outstanding or the update FIFO is full.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   res_*_i / pred_*_i  : resolved branch (valid/ready) and the frontend's prediction for it
//   flush_o             : one-cycle backend flush pulse on a mispredict
//   redir_*             : corrected fetch PC, valid/ready, held stable until accepted
//   upd_*               : head of the predictor-update FIFO, valid/ready
//   br_cnt_o, mis_cnt_o : performance counters, built only when PERF_CNT_EN is defined (else tied to 0)
//
// Optional feature macro: PERF_CNT_EN

module b_redirect_ctrl #(
    parameter int unsigned UPD_DEPTH = 4,
    parameter int unsigned PC_STEP   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        res_valid_i,
    output logic        res_ready_o,
    input  logic [31:0] res_pc_i,
    input  logic        res_jump_i,
    input  logic [31:0] res_target_i,
    input  logic        pred_jump_i,
    input  logic [31:0] pred_target_i,
    output logic        flush_o,
    output logic        redir_valid_o,
    input  logic        redir_ready_i,
    output logic [31:0] redir_pc_o,
    output logic        upd_valid_o,
    input  logic        upd_ready_i,
    output logic [31:0] upd_pc_o,
    output logic        upd_jump_o,
    output logic [31:0] upd_target_o,
    output logic [31:0] br_cnt_o,
    output logic [31:0] mis_cnt_o
);

    localparam int unsigned AW = $clog2(UPD_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_REDIR = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]    state_q, state_d;
    logic          flush_q, flush_d;
    logic [31:0]   redir_pc_q, redir_pc_d;
    // Low during reset and set on the first edge after release, so that
    // res_ready_o stays 0 while rst is held and is purely register-driven.
    logic          live_q, live_d;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0]   mem_pc_q  [UPD_DEPTH];
    logic [31:0]   mem_pc_d  [UPD_DEPTH];
    logic          mem_jmp_q [UPD_DEPTH];
    logic          mem_jmp_d [UPD_DEPTH];
    logic [31:0]   mem_tgt_q [UPD_DEPTH];
    logic [31:0]   mem_tgt_d [UPD_DEPTH];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        fifo_full;
    logic        fifo_empty;
    logic        res_fire;
    logic        upd_fire;
    logic        mis;
    logic [31:0] corr_pc;

    assign fifo_full  = (cnt_q == CW'(UPD_DEPTH));
    assign fifo_empty = (cnt_q == '0);

    assign res_ready_o = live_q && (state_q == S_IDLE) && !fifo_full;
    assign res_fire    = res_valid_i && res_ready_o;
    assign upd_fire    = !fifo_empty && upd_ready_i;

    // A not-taken branch predicted not-taken is correct whatever the targets say.
    assign mis = (res_jump_i != pred_jump_i) ||
                 (res_jump_i && pred_jump_i && (res_target_i != pred_target_i));

    // Fall-through PC wraps naturally in 32 bits.
    assign corr_pc = res_jump_i ? res_target_i : (res_pc_i + 32'(PC_STEP));

    // ------------------------------------------------------------------
    // Redirect FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        redir_pc_d = redir_pc_q;
        flush_d    = 1'b0;
        live_d     = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (res_fire && mis) begin
                    state_d    = S_REDIR;
                    redir_pc_d = corr_pc;
                    flush_d    = 1'b1;
                end
            end
            S_REDIR: begin
                if (redir_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Predictor-update FIFO (power-of-two depth, pointers wrap naturally)
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        mem_pc_d  = mem_pc_q;
        mem_jmp_d = mem_jmp_q;
        mem_tgt_d = mem_tgt_q;

        if (res_fire) begin
            mem_pc_d[wr_ptr_q]  = res_pc_i;
            mem_jmp_d[wr_ptr_q] = res_jump_i;
            mem_tgt_d[wr_ptr_q] = res_target_i;
            wr_ptr_d            = wr_ptr_q + AW'(1);
        end
        if (upd_fire) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({res_fire, upd_fire})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            flush_q    <= 1'b0;
            redir_pc_q <= '0;
            live_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < UPD_DEPTH; i++) begin
                mem_pc_q[i]  <= '0;
                mem_jmp_q[i] <= 1'b0;
                mem_tgt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            flush_q    <= flush_d;
            redir_pc_q <= redir_pc_d;
            live_q     <= live_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            mem_pc_q   <= mem_pc_d;
            mem_jmp_q  <= mem_jmp_d;
            mem_tgt_q  <= mem_tgt_d;
        end
    end

    assign flush_o       = flush_q;
    assign redir_valid_o = (state_q == S_REDIR);
    assign redir_pc_o    = redir_pc_q;

    // Head is zeroed when empty so nothing stale leaks out; while valid it
    // only moves on a pop, so it holds under upd_ready_i=0.
    assign upd_valid_o  = !fifo_empty;
    assign upd_pc_o     = fifo_empty ? 32'h0 : mem_pc_q[rd_ptr_q];
    assign upd_jump_o   = fifo_empty ? 1'b0  : mem_jmp_q[rd_ptr_q];
    assign upd_target_o = fifo_empty ? 32'h0 : mem_tgt_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef PERF_CNT_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (res_fire) begin
            br_cnt_d = br_cnt_q + 32'd1;
            if (mis) begin
                mis_cnt_d = mis_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign br_cnt_o  = br_cnt_q;
    assign mis_cnt_o = mis_cnt_q;
`else
    assign br_cnt_o  = 32'h0;
    assign mis_cnt_o = 32'h0;
`endif

endmodule
